// File: rtl/sysarray_pkg.sv
// Shared definitions for the host<->device UART framing (RX deframer and TX framer).
package sysarray_pkg;

  typedef enum logic [1:0] {
    RX_LEN,
    RX_HEADER,
    RX_DATA,
    RX_DRAIN
  } rx_state_t;

  localparam int LEN_BYTES        = 4;
  localparam int HEADER_BYTES     = 1;
  localparam int WORD_BYTES       = 4;
  localparam int BLOCK_ADDR_SHIFT = 8;

endpackage

// File: rtl/byte_word_packer.sv
// Packs a stream of bytes into little-endian words; the first byte lands in bits [7:0].
// The finished word sits in its own output register so the next byte can start shifting
// in on the same cycle the word is presented.
module byte_word_packer
  import sysarray_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             word_valid,
  output logic [WIDTH-1:0] word
);

  logic [1:0]       count;
  logic [WIDTH-9:0] shift;

  // Byte lane counter, partial-word shifter and registered word output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      shift      <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        count <= '0;
      end else if (in_valid) begin
        if (count == 2'(WORD_BYTES - 1)) begin
          word       <= {in_byte, shift};
          word_valid <= 1'b1;
          count      <= '0;
        end else begin
          shift <= {in_byte, shift[WIDTH-9:8]};
          count <= count + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// UART receive deframer: [4B LE bytecount N][1B header][N-1 payload bytes].
// Payload is packed into LE words and written to block memory at (header << 8) + word_idx.
// Optional inter-byte timeout is built when the macro RX_TIMEOUT_EN is defined; the
// TIMEOUT_CYCLES parameter only exists in that build.
module uart_frame_rx
  import sysarray_pkg::*;
#(
  parameter int BITWIDTH  = 32,
  parameter int MAX_WORDS = 256
`ifdef RX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 100000
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                mem_wr_en,
  output logic [BITWIDTH-1:0] mem_wr_addr,
  output logic [BITWIDTH-1:0] mem_wr_data,
  output logic                frame_done,
  output logic [7:0]          frame_header,
  output logic                frame_error,
  output logic                busy
);

  rx_state_t           state;
  rx_state_t           state_next;
  logic [1:0]          len_cnt;
  logic [23:0]         len_low;
  logic [31:0]         len_reg;
  logic [31:0]         bytes_left;
  logic [BITWIDTH-1:0] word_idx;
  logic [31:0]         full_len;
  logic [31:0]         len_m1;
  logic                len_ok;
  logic                len_last;
  logic                data_byte;
  logic                word_end;
  logic                frame_last;
  logic                header_byte;
  logic                done_next;
  logic                error_next;
  logic                timeout_hit;

  assign full_len    = {rx_data, len_low};
  assign len_m1      = full_len - 32'd1;
  assign len_ok      = (full_len != 32'd0) && (len_m1[1:0] == 2'b00) &&
                       ((len_m1 >> 2) <= 32'(MAX_WORDS));
  assign len_last    = rx_valid && (state == RX_LEN) && (len_cnt == 2'(LEN_BYTES - 1));
  assign header_byte = rx_valid && (state == RX_HEADER);
  assign data_byte   = rx_valid && (state == RX_DATA);
  assign word_end    = data_byte && (bytes_left[1:0] == 2'b01);
  assign frame_last  = data_byte && (bytes_left == 32'd1);
  assign busy        = (state != RX_LEN) || (len_cnt != 2'd0);

`ifdef RX_TIMEOUT_EN
  logic [31:0] idle_cnt;

  assign timeout_hit = busy && !rx_valid && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Idle counter: restarts on every byte and whenever no frame is in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (rx_valid || !busy || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Frame parser next-state and the done/error decisions for the following cycle.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    error_next = 1'b0;
    case (state)
      RX_LEN: begin
        if (len_last) begin
          if (len_ok) begin
            state_next = RX_HEADER;
          end else begin
            error_next = 1'b1;
            state_next = (full_len == 32'd0) ? RX_LEN : RX_DRAIN;
          end
        end
      end
      RX_HEADER: begin
        if (rx_valid) begin
          if (len_reg == 32'd1) begin
            done_next  = 1'b1;
            state_next = RX_LEN;
          end else begin
            state_next = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (frame_last) begin
          done_next  = 1'b1;
          state_next = RX_LEN;
        end
      end
      RX_DRAIN: begin
        if (rx_valid && (bytes_left == 32'd1)) begin
          state_next = RX_LEN;
        end
      end
      default: state_next = RX_LEN;
    endcase
    if (timeout_hit) begin
      state_next = RX_LEN;
      error_next = 1'b1;
      done_next  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RX_LEN;
    end else begin
      state <= state_next;
    end
  end

  // Length collection, header latch, byte/word bookkeeping and registered pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_cnt      <= '0;
      len_low      <= '0;
      len_reg      <= '0;
      bytes_left   <= '0;
      word_idx     <= '0;
      frame_header <= '0;
      mem_wr_addr  <= '0;
      frame_done   <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      frame_done  <= done_next;
      frame_error <= error_next;
      if (timeout_hit) begin
        len_cnt <= '0;
      end else begin
        case (state)
          RX_LEN: begin
            if (len_last) begin
              len_cnt    <= '0;
              len_reg    <= full_len;
              bytes_left <= full_len;
            end else if (rx_valid) begin
              len_low <= {rx_data, len_low[23:8]};
              len_cnt <= len_cnt + 2'd1;
            end
          end
          RX_HEADER: begin
            if (rx_valid) begin
              frame_header <= rx_data;
              word_idx     <= '0;
              bytes_left   <= len_reg - 32'(HEADER_BYTES);
            end
          end
          RX_DATA: begin
            if (data_byte) begin
              bytes_left <= bytes_left - 32'd1;
              if (word_end) begin
                mem_wr_addr <= (BITWIDTH'(frame_header) << BLOCK_ADDR_SHIFT) + word_idx;
                word_idx    <= word_idx + BITWIDTH'(1);
              end
            end
          end
          RX_DRAIN: begin
            if (rx_valid) begin
              bytes_left <= bytes_left - 32'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  byte_word_packer #(
    .WIDTH(BITWIDTH)
  ) packer (
    .clock     (clock),
    .reset     (reset),
    .clear     (header_byte || timeout_hit),
    .in_valid  (data_byte),
    .in_byte   (rx_data),
    .word_valid(mem_wr_en),
    .word      (mem_wr_data)
  );

endmodule
